pipe_ctrl: RTL

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 137 +++++++++++++
 1 files changed

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline hazard, branch-flush and data-memory wait controller
module pipe_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        ex_memread,
  input  logic [4:0]  ex_rd,
  input  logic        mem_branch,
  input  logic        mem_zero,
  input  logic        mem_memread,
  input  logic        mem_memwrite,
  input  logic        dmem_ready,
  output logic        dmem_req,
  output logic        pc_write,
  output logic        pc_src,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        exmem_hold,
  output logic        exmem_flush,
  output logic        bus_error,
  output logic [15:0] stall_cnt
);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_ERROR    = 2'd2;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  logic [1:0] state, state_nxt;
  logic [7:0] wait_cnt, wait_cnt_nxt;
  logic       mem_access, mem_stall, branch_taken, load_use;

  // Hazard detection and memory-stall decode from the current state
  always_comb begin
    mem_access   = mem_memread | mem_memwrite;
    branch_taken = mem_branch & mem_zero;
    load_use     = ex_memread && (ex_rd != 5'd0) &&
                   ((ex_rd == id_rs1) || (ex_rd == id_rs2));
    case (state)
      ST_MEM_WAIT: mem_stall = ~dmem_ready;
      ST_ERROR:    mem_stall = 1'b1;
      default:     mem_stall = mem_access & ~dmem_ready;
    endcase
  end

  // Next-state logic: a missed access enters MEM_WAIT, too many wait cycles lock into ERROR
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      ST_MEM_WAIT: begin
        if (dmem_ready) begin
          state_nxt    = ST_RUN;
          wait_cnt_nxt = 8'd0;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nxt = ST_ERROR;
        end else begin
          wait_cnt_nxt = wait_cnt + 8'd1;
        end
      end
      ST_ERROR: state_nxt = ST_ERROR;
      default: begin
        state_nxt = ST_RUN;
        if (mem_access && !dmem_ready) begin
          state_nxt    = ST_MEM_WAIT;
          wait_cnt_nxt = 8'd0;
        end
      end
    endcase
  end

  // State register; reset abandons any outstanding access
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_RUN;
      wait_cnt <= 8'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Output decode with priority memory stall > branch taken > load-use; reset forces a flushed pipe
  always_comb begin
    dmem_req    = 1'b0;
    pc_write    = 1'b1;
    pc_src      = 1'b0;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_hold  = 1'b0;
    exmem_flush = 1'b0;
    bus_error   = 1'b0;
    if (!rst_n) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else begin
      case (state)
        ST_MEM_WAIT: dmem_req = 1'b1;
        ST_ERROR:    bus_error = 1'b1;
        default:     dmem_req = mem_access;
      endcase
      if (mem_stall) begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        exmem_hold = 1'b1;
      end else if (branch_taken) begin
        pc_src      = 1'b1;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
      end else if (load_use) begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        idex_flush = 1'b1;
      end
    end
  end

  // Saturating count of cycles in which the PC was held
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= 16'd0;
    end else if (!pc_write && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule
